// File: rtl/brick_sequencer.sv
// brick_sequencer: drives a single 2b x 2b brick multiplier slice by slice and
// shift-accumulates the brick products into one full-precision signed result.
// Optional feature macro: BRICK_SEQ_ZERO_SKIP_EN -- when defined, operations
// with a zero (masked) operand bypass the slice loop and complete immediately.
module brick_sequencer #(
  parameter int unsigned MAX_BITS = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [MAX_BITS-1:0]       i_activation,
  input  logic [MAX_BITS-1:0]       i_weight,
  input  logic [1:0]                i_a_prec,
  input  logic [1:0]                i_w_prec,
  input  logic                      i_A_signed,
  input  logic                      i_W_signed,
  output logic [1:0]                o_brick_act,
  output logic [1:0]                o_brick_wgt,
  output logic                      o_brick_A_signed,
  output logic                      o_brick_W_signed,
  input  logic signed [4:0]         i_brick_prod,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic signed [2*MAX_BITS:0] o_result
);

  localparam int unsigned ACC_W = 2 * MAX_BITS + 1;
  localparam int unsigned NSL   = MAX_BITS / 2;
  localparam int unsigned IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Precision code to operand width in bits, clamped to MAX_BITS.
  function automatic int unsigned prec_bits(input logic [1:0] p);
    int unsigned b;
    case (p)
      2'b00:   b = 2;
      2'b01:   b = 4;
      2'b10:   b = 8;
      default: b = MAX_BITS;
    endcase
    if (b > MAX_BITS) b = MAX_BITS;
    return b;
  endfunction

  function automatic logic [MAX_BITS-1:0] prec_mask(input logic [1:0] p);
    logic [MAX_BITS-1:0] m;
    int unsigned         b;
    b = prec_bits(p);
    for (int unsigned k = 0; k < MAX_BITS; k++) m[k] = (k < b);
    return m;
  endfunction

  // Index of the most significant (last) 2-bit slice.
  function automatic logic [IDX_W-1:0] prec_last(input logic [1:0] p);
    return IDX_W'(prec_bits(p) / 2 - 1);
  endfunction

  state_e                  state_q, state_d;
  logic [MAX_BITS-1:0]     act_q, act_d, wgt_q, wgt_d;
  logic [IDX_W-1:0]        ia_q, ia_d, iw_q, iw_d;
  logic [IDX_W-1:0]        na_last_q, na_last_d, nw_last_q, nw_last_d;
  logic                    asg_q, asg_d, wsg_q, wsg_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic [MAX_BITS-1:0]     act_m, wgt_m;
  logic [IDX_W:0]          act_lsb, wgt_lsb;
  logic [IDX_W+1:0]        shamt;
  logic signed [ACC_W-1:0] prod_ext;

  assign act_m    = i_activation & prec_mask(i_a_prec);
  assign wgt_m    = i_weight & prec_mask(i_w_prec);
  assign act_lsb  = {ia_q, 1'b0};
  assign wgt_lsb  = {iw_q, 1'b0};
  assign shamt    = {({1'b0, ia_q} + {1'b0, iw_q}), 1'b0};
  assign prod_ext = ACC_W'(i_brick_prod);

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      act_q     <= '0;
      wgt_q     <= '0;
      ia_q      <= '0;
      iw_q      <= '0;
      na_last_q <= '0;
      nw_last_q <= '0;
      asg_q     <= 1'b0;
      wsg_q     <= 1'b0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      wgt_q     <= wgt_d;
      ia_q      <= ia_d;
      iw_q      <= iw_d;
      na_last_q <= na_last_d;
      nw_last_q <= nw_last_d;
      asg_q     <= asg_d;
      wsg_q     <= wsg_d;
      acc_q     <= acc_d;
    end
  end

  // Next-state, slice iteration, accumulation and port outputs.
  always_comb begin
    state_d          = state_q;
    act_d            = act_q;
    wgt_d            = wgt_q;
    ia_d             = ia_q;
    iw_d             = iw_q;
    na_last_d        = na_last_q;
    nw_last_d        = nw_last_q;
    asg_d            = asg_q;
    wsg_d            = wsg_q;
    acc_d            = acc_q;
    o_ready          = 1'b0;
    o_valid          = 1'b0;
    o_result         = '0;
    o_brick_act      = '0;
    o_brick_wgt      = '0;
    o_brick_A_signed = 1'b0;
    o_brick_W_signed = 1'b0;

    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          act_d     = act_m;
          wgt_d     = wgt_m;
          na_last_d = prec_last(i_a_prec);
          nw_last_d = prec_last(i_w_prec);
          asg_d     = i_A_signed;
          wsg_d     = i_W_signed;
          acc_d     = '0;
          ia_d      = '0;
          iw_d      = '0;
          state_d   = RUN;
`ifdef BRICK_SEQ_ZERO_SKIP_EN
          if ((act_m == '0) || (wgt_m == '0)) state_d = DONE;
`else
`endif
        end
      end

      RUN: begin
        o_brick_act      = act_q[act_lsb +: 2];
        o_brick_wgt      = wgt_q[wgt_lsb +: 2];
        // Only the top slice of a signed operand carries its sign.
        o_brick_A_signed = asg_q & (ia_q == na_last_q);
        o_brick_W_signed = wsg_q & (iw_q == nw_last_q);
        acc_d            = acc_q + (prod_ext <<< shamt);
        if (iw_q == nw_last_q) begin
          iw_d = '0;
          if (ia_q == na_last_q) state_d = DONE;
          else                   ia_d    = ia_q + 1'b1;
        end else begin
          iw_d = iw_q + 1'b1;
        end
      end

      DONE: begin
        o_valid  = 1'b1;
        o_result = acc_q;
        if (i_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_brick_sequencer.sv
// Scoreboard bench for brick_sequencer: a behavioural brick model closes the
// brick loop, stimulus pushes expected results, a monitor pops on handshake.
module tb_brick_sequencer;

  localparam int unsigned MB = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_valid, o_ready, i_ready, o_valid;
  logic [MB-1:0]     act, wgt;
  logic [1:0]        a_prec, w_prec;
  logic              a_sg, w_sg;
  logic [1:0]        b_act, b_wgt;
  logic              b_as, b_ws;
  logic signed [4:0] brick_prod;
  logic signed [2*MB:0] result;

  brick_sequencer #(.MAX_BITS(MB)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_activation    (act),
    .i_weight        (wgt),
    .i_a_prec        (a_prec),
    .i_w_prec        (w_prec),
    .i_A_signed      (a_sg),
    .i_W_signed      (w_sg),
    .o_brick_act     (b_act),
    .o_brick_wgt     (b_wgt),
    .o_brick_A_signed(b_as),
    .o_brick_W_signed(b_ws),
    .i_brick_prod    (brick_prod),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_result        (result)
  );

  always #5 clk = ~clk;

  // Behavioural 2b x 2b brick.
  int av, wv;
  always_comb begin
    av = int'(b_act);
    wv = int'(b_wgt);
    if (b_as && b_act[1]) av = av - 4;
    if (b_ws && b_wgt[1]) wv = wv - 4;
    brick_prod = 5'(av * wv);
  end

  typedef struct {
    longint      res;
    int unsigned run;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Monitor: counts RUN cycles and checks each result on handshake.
  initial begin
    int unsigned run_cnt;
    exp_t        e;
    run_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_cnt = 0;
      end else if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_result: got %0d expected none", longint'(result));
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, longint'(result), e.res);
          chk({e.name, "_run_cycles"}, longint'(run_cnt), longint'(e.run));
        end
        run_cnt = 0;
      end else if (!o_ready && !o_valid) begin
        run_cnt++;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] w,
                      input logic [1:0] ap, input logic [1:0] wp,
                      input logic as_, input logic ws_, input bit push,
                      input longint res, input int unsigned run, input string name);
    int unsigned t;
    exp_t        e;
    t = 0;
    @(negedge clk);
    while (!o_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready) begin
      n_chk++;
      $display("FAIL %s_accept_timeout: got o_ready=0 expected 1", name);
      return;
    end
    act = a; wgt = w; a_prec = ap; w_prec = wp; a_sg = as_; w_sg = ws_;
    i_valid = 1'b1;
    if (push) begin
      e.res = res; e.run = run; e.name = name;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int unsigned t;
    t = 0;
    @(negedge clk);
    while (!o_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!o_valid) begin
      n_chk++;
      $display("FAIL %s_valid_timeout: got o_valid=0 expected 1", name);
    end
  endtask

  task automatic drain();
    int unsigned t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", longint'(sb.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    act = '0; wgt = '0; a_prec = '0; w_prec = '0; a_sg = 1'b0; w_sg = 1'b0;
    #2;
    chk("rst_ready", longint'(o_ready), 1);
    chk("rst_valid", longint'(o_valid), 0);
    chk("rst_result", longint'(result), 0);
    chk("rst_brick", longint'({b_act, b_wgt, b_as, b_ws}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 2b x 2b signed: -1 * -2
    send(8'h03, 8'h02, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2, 1, "t1");
    @(negedge clk);
    chk("t1_slices", longint'({b_act, b_wgt}), 4'b1110);
    chk("t1_sign_flags", longint'({b_as, b_ws}), 2'b11);

    send(8'hFF, 8'hFF, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 65025, 16, "t2");

    // Distinct slices expose issue order: act slices 0..3, wgt slices 3..0.
    send(8'hE4, 8'h1B, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 6156, 16, "order");
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("order_slice", longint'({b_act, b_wgt}), longint'(((k / 4) << 2) | (3 - (k % 4))));
    end

    send(8'h80, 8'h7F, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, -16256, 16, "t3a");
    send(8'hC8, 8'h0D, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1, -600, 8, "t3b");
    // Bits above precision are masked: 15 * 3.
    send(8'hFF, 8'hFF, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 45, 2, "mask");
    // Precision code 11 clamps to MAX_BITS: 255 * -1.
    send(8'hFF, 8'h03, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, -255, 4, "clamp");
    drain();

    // Back-pressure in DONE while i_valid pulses.
    @(posedge clk);
    #1 i_ready = 1'b0;
    send(8'h05, 8'h06, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 30, 4, "t4");
    wait_valid("t4");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 begin
        i_valid = 1'b1; act = 8'h01; wgt = 8'h01; a_prec = 2'b00; w_prec = 2'b00;
      end
      @(negedge clk);
      chk("t4_hold_valid", longint'(o_valid), 1);
      chk("t4_hold_result", longint'(result), 30);
      chk("t4_hold_ready", longint'(o_ready), 0);
    end
    @(posedge clk);
    #1 begin
      i_valid = 1'b0; i_ready = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    chk("t4_idle_ready", longint'(o_ready), 1);
    chk("t4_idle_valid", longint'(o_valid), 0);

    // Reset during the third RUN cycle discards the operation.
    send(8'h64, 8'h32, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 0, 0, "t5");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", longint'(o_valid), 0);
    chk("t5_rst_ready", longint'(o_ready), 1);
    chk("t5_rst_result", longint'(result), 0);
    chk("t5_rst_brick", longint'({b_act, b_wgt, b_as, b_ws}), 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h9C, 8'h32, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1, -5000, 16, "t5_after");

    // Zero operand.
`ifdef BRICK_SEQ_ZERO_SKIP_EN
    send(8'h00, 8'h4D, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 0, 0, "t6");
`else
    send(8'h00, 8'h4D, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 0, 16, "t6");
`endif
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
